// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX-stage forwarding / hazard logic.
package pipe_pkg;

  // Default architectural register address width.
  localparam int REG_AW = 5;

  // Select code meaning "take the operand from the register file".
  localparam int FWD_NONE = 0;

  // One shadow entry per post-EX pipeline stage.
  typedef struct packed {
    logic              v;   // stage holds a real register write
    logic [REG_AW-1:0] rd;  // destination register of that write
    logic              ld;  // the producer is a load (data late)
  } entry_t;

endpackage

// File: rtl/fwd_src_match.sv
// Priority matcher for one source operand against all in-flight entries.
// The youngest (lowest index) matching entry wins; ld_hit flags a load
// sitting in the youngest entry that this operand depends on.
module fwd_src_match #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int SELW   = $clog2(DEPTH + 1)
) (
  input  logic                    used,
  input  logic [REG_AW-1:0]       addr,
  input  logic [DEPTH-1:0]        v,
  input  logic [DEPTH*REG_AW-1:0] rd,
  input  logic                    ld0,
  output logic [SELW-1:0]         sel,
  output logic                    ld_hit
);
  import pipe_pkg::*;

  logic [DEPTH-1:0] match;

  // Per-entry address compare; register 0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = used & v[gi] & (rd[gi*REG_AW +: REG_AW] == addr) &
                         (addr != '0);
    end
  endgenerate

  // Walk from oldest to youngest so the youngest match overrides.
  always_comb begin
    sel = SELW'(FWD_NONE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) sel = SELW'(k + 1);
    end
    ld_hit = match[0] & ld0;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select and load-use hazard detection. A shadow shift
// register tracks destination registers of instructions past EX; each source
// operand of the EX instruction is matched against it.
module fwd_hazard_unit #(
  parameter int REG_AW  = pipe_pkg::REG_AW,
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  localparam int SELW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hold_i,
  input  logic                      flush_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_AW-1:0]         ex_rd_i,
  input  logic [NUM_SRC-1:0]        src_used_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
  output logic                      hazard_stall_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);
  import pipe_pkg::*;

  entry_t                  entries_reg [DEPTH];
  logic [CNT_W-1:0]        stall_cnt_reg;

  logic [DEPTH-1:0]        v_vec;
  logic [DEPTH*REG_AW-1:0] rd_vec;
  logic [NUM_SRC-1:0]      ld_hit;
  logic                    hazard;
  logic                    bubble;

  // Flatten the entry array for the per-source matchers.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign v_vec[gi]                   = entries_reg[gi].v;
      assign rd_vec[gi*REG_AW +: REG_AW] = entries_reg[gi].rd;
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SELW   (SELW)
      ) u_match (
        .used   (src_used_i[gi]),
        .addr   (src_addr_i[gi*REG_AW +: REG_AW]),
        .v      (v_vec),
        .rd     (rd_vec),
        .ld0    (entries_reg[0].ld),
        .sel    (fwd_sel_o[gi*SELW +: SELW]),
        .ld_hit (ld_hit[gi])
      );
    end
  endgenerate

  // A killed instruction never stalls, so flush overrides the hazard.
  assign hazard = ex_valid_i & ~flush_i & (|ld_hit);
  assign bubble = flush_i | hazard | ~ex_valid_i;

  assign hazard_stall_o = hazard;
  assign stall_cnt_o    = stall_cnt_reg;

  // Advance the shadow pipeline and count stall cycles unless frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) entries_reg[k] <= '0;
      stall_cnt_reg <= '0;
    end else if (!hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) entries_reg[k] <= entries_reg[k-1];
      if (bubble) begin
        entries_reg[0] <= '0;
      end else begin
        entries_reg[0].v  <= ex_regwrite_i & (ex_rd_i != '0);
        entries_reg[0].rd <= ex_rd_i;
        entries_reg[0].ld <= ex_is_load_i;
      end
      if (hazard && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
